// File: rtl/banco_de_registradores_pkg.sv
// Shared register-file constants and types for decode, register file and writeback.
package banco_de_registradores_pkg;

    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_ADDR_WIDTH = 5;
    localparam int unsigned RF_NUM_REGS   = 2 ** RF_ADDR_WIDTH;
    localparam int unsigned REG_ZERO      = 0;

    typedef logic [RF_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [RF_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/banco_de_registradores_read_port.sv
// Combinational register read mux; index REG_ZERO always returns zero.
module banco_de_registradores_read_port
    import banco_de_registradores_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH],
    output logic [DATA_WIDTH-1:0] data
);

    // Zero is forced here so r0 reads 0 even before the first reset.
    always_comb begin
        data = '0;
        if (addr != ADDR_WIDTH'(REG_ZERO)) begin
            data = regs[addr];
        end
    end

endmodule

// File: rtl/banco_de_registradores.sv
// MIPS-style register file: 2 asynchronous read ports, 1 synchronous write port, r0 hardwired to 0.
module banco_de_registradores
    import banco_de_registradores_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] Read_1,
    input  logic [ADDR_WIDTH-1:0] Read_2,
    input  logic [DATA_WIDTH-1:0] Data_to_write,
    input  logic [ADDR_WIDTH-1:0] Address_to_write,
    input  logic                  Signal_write,
    input  logic                  Signal_reset,
    input  logic                  Clock_in,
    output logic [DATA_WIDTH-1:0] Out_1,
    output logic [DATA_WIDTH-1:0] Out_2
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (Signal_write && (Address_to_write != ADDR_WIDTH'(REG_ZERO))) begin
            regs_d[Address_to_write] = Data_to_write;
        end
    end

    // Reset wins over a coincident write.
    always_ff @(posedge Clock_in) begin
        if (Signal_reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    banco_de_registradores_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_port_1 (
        .addr (Read_1),
        .regs (regs_q),
        .data (Out_1)
    );

    banco_de_registradores_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_port_2 (
        .addr (Read_2),
        .regs (regs_q),
        .data (Out_2)
    );

endmodule

// File: tb/tb_banco_de_registradores.sv
// Randomized self-checking bench for banco_de_registradores against an array reference model.
module tb_banco_de_registradores;

    logic        clk = 1'b0;
    logic [4:0]  rd1, rd2, wa;
    logic [31:0] wd;
    logic        we, rst;
    logic [31:0] out1, out2;

    logic [31:0] mdl [32];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    banco_de_registradores dut (
        .Read_1           (rd1),
        .Read_2           (rd2),
        .Data_to_write    (wd),
        .Address_to_write (wa),
        .Signal_write     (we),
        .Signal_reset     (rst),
        .Clock_in         (clk),
        .Out_1            (out1),
        .Out_2            (out2)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : mdl[a];
    endfunction

    // One rising edge; the model applies the same edge rules, then outputs settle.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        end else if (we && wa != 5'd0) begin
            mdl[wa] = wd;
        end
        #1;
    endtask

    task automatic check_reads(input string tag);
        #1;
        check_value({tag, "_out1"}, out1, model_read(rd1));
        check_value({tag, "_out2"}, out2, model_read(rd2));
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; wa = '0; wd = '0; rd1 = '0; rd2 = '0;
        #1;
        check_value("r0_before_reset", out1, 32'd0);

        // Reset and full sweep
        rst = 1'b1; rd1 = 5'd0; rd2 = 5'd1;
        tick();
        rst = 1'b0;
        check_value("reset_out1", out1, 32'd0);
        check_value("reset_out2", out2, 32'd0);
        for (int i = 0; i < 32; i++) begin
            rd1 = 5'(i); rd2 = 5'(31 - i);
            #1;
            check_value("reset_sweep1", out1, 32'd0);
            check_value("reset_sweep2", out2, 32'd0);
        end

        // Write to r0 is ignored
        we = 1'b1; wa = 5'd0; wd = 32'd1; rd1 = 5'd0; rd2 = 5'd1;
        tick();
        check_value("r0_write_out1", out1, 32'd0);
        check_value("r0_write_out2", out2, 32'd0);

        // Normal writes
        wa = 5'd5;  wd = 32'hDEADBEEF; tick();
        wa = 5'd31; wd = 32'h00000001; tick();
        we = 1'b0;
        rd1 = 5'd5; rd2 = 5'd31;
        #1;
        check_value("r5_read", out1, 32'hDEADBEEF);
        check_value("r31_read", out2, 32'h00000001);

        // Write disabled
        wa = 5'd5; wd = 32'h12345678;
        tick();
        check_value("we0_r5", out1, 32'hDEADBEEF);

        // Read-during-write, no bypass
        we = 1'b1; wa = 5'd7; wd = 32'hA; tick();
        rd1 = 5'd7; rd2 = 5'd7; wd = 32'hB;
        #1;
        check_value("rdw_before1", out1, 32'hA);
        check_value("rdw_before2", out2, 32'hA);
        tick();
        check_value("rdw_after1", out1, 32'hB);
        check_value("rdw_after2", out2, 32'hB);

        // Reset beats write
        rst = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'hFFFFFFFF;
        tick();
        rst = 1'b0; we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd1 = 5'(i); rd2 = 5'd9;
            #1;
            check_value("rst_vs_wr_sweep", out1, 32'd0);
            check_value("rst_vs_wr_r9", out2, 32'd0);
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            we  = $urandom_range(0, 3) != 0;
            wa  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            rd1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rd2 = ($urandom_range(0, 7) == 0) ? rd1 : 5'($urandom_range(0, 31));
            check_reads("rand_pre");
            tick();
            rst = 1'b0; we = 1'b0;
            check_reads("rand_post");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
